muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001: Parameter XLEN, default 64, sets the datapath width; legal values are 32 and 64.
REQ-002: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: in_valid_i  input  1  an operation is offered.
REQ-005: in_ready_o  output  1  the unit accepts an operation this cycle.
REQ-006: funct3_i  input  3  RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007: word_i  input  1  selects the 32-bit W variant; ignored when XLEN=32.
REQ-008: srcA_i, srcB_i  input  XLEN  operands (A = multiplicand/dividend).
REQ-009: flush_i  input  1  aborts any in-flight or completed-but-unconsumed operation.
REQ-010: out_valid_o  output  1  result_o holds a completed result.
REQ-011: out_ready_i  input  1  consumer takes the result.
REQ-012: result_o  output  XLEN  result.
REQ-013: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014: The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-015: in_ready_o SHALL equal (state==IDLE) & ~flush_i; accept = in_valid_i & in_ready_o, with funct3_i, word_i and operands latched at the accept edge.
REQ-016: MUL path: accept -> MUL -> DONE; out_valid_o SHALL rise exactly 2 edges after the accept edge.
REQ-017: MUL SHALL give low XLEN bits; MULH signed x signed high; MULHSU signed A x unsigned B high; MULHU unsigned high.
REQ-018: word_i with funct3 000-011 SHALL give MULW: low 32 bits of the product, sign-extended to 64.
REQ-019: DIV path: iterative radix-2 restoring division, one quotient bit per cycle, W = 32 (word) or XLEN iterations; out_valid_o SHALL rise W+1 edges after the accept edge.
REQ-020: Signed ops SHALL divide operand magnitudes and fix signs at completion: quotient negative iff signs differ, remainder takes the dividend's sign.
REQ-021: Divide by zero SHALL yield quotient all-ones and remainder = dividend (W-width values for word ops).
REQ-022: Signed overflow (most-negative / -1) SHALL yield quotient = dividend and remainder = 0.
REQ-023: Word divide ops SHALL use operand bits [31:0], sign- or zero-extended per signedness, and sign-extend the 32-bit result to 64.
REQ-024: In DONE, result_o and out_valid_o SHALL hold stable until out_ready_i; at the edge where out_valid_o & out_ready_i, the FSM SHALL return to IDLE.
REQ-025: No accept SHALL occur in the same cycle as a result handoff; the next accept is possible at the earliest one cycle later.
REQ-026: flush_i high at an edge SHALL force IDLE and drop out_valid_o from any state; flush_i SHALL win over out_ready_i and in_valid_i.
REQ-027: Inputs other than handshakes SHALL be don't-care outside the accept cycle.

Reset
REQ-028: While reset is low: state=IDLE, out_valid_o=0, result_o=0, busy_o=0, iteration counter=0, operand/partial-remainder registers=0.
REQ-029: Reset asserted mid-operation SHALL discard the operation; in_ready_o SHALL be 1 in the first cycle after release.

Configuration
REQ-030: Macro MULDIV_DIV_FASTPATH_EN, when defined, SHALL detect divide-by-zero and signed overflow at accept and go straight to DONE: out_valid_o 1 edge after accept.
REQ-031: Without MULDIV_DIV_FASTPATH_EN, those cases SHALL run the full W-iteration path with the latency of REQ-019, producing the results of REQ-021/REQ-022.

Verification
REQ-032: XLEN=64, MULH A=-2, B=3 -> result 0xFFFFFFFFFFFFFFFF, out_valid 2 edges after accept.
REQ-033: XLEN=64, DIV A=-7, B=2 -> 0xFFFFFFFFFFFFFFFD after 65 edges; REM same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-034: DIVUW A=0x00000000_80000000, B=0 -> 0xFFFFFFFFFFFFFFFF; REMUW -> 0xFFFFFFFF80000000; latency 33 edges, or 1 edge with the macro defined.
REQ-035: DIV A=0x8000000000000000, B=-1 -> 0x8000000000000000; REM -> 0.
REQ-036: out_ready_i held low 5 cycles after DONE -> result stable and in_ready_o low throughout; flush_i pulsed at iteration 10 -> IDLE next edge, no out_valid_o, next op correct.
REQ-037: Reset asserted at iteration 20 of a DIV -> all outputs at reset values immediately; in_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV64/RV32 M-extension multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// Optional MULDIV_DIV_FASTPATH_EN sends divide-by-zero and signed overflow straight to DONE.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t r_state, w_next;

  function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] o;
    o = v;
    for (int unsigned i = 32; i < XLEN; i++) o[i] = v[31];
    return o;
  endfunction

  function automatic logic [XLEN-1:0] f_zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] o;
    o = '0;
    o[31:0] = v[31:0];
    return o;
  endfunction

  // Divide-by-zero / overflow answers, taken from the raw dividend.
  function automatic logic [XLEN-1:0] f_special(input logic [XLEN-1:0] a, input logic is_rem,
                                                input logic dbz, input logic word);
    logic [XLEN-1:0] v;
    if (dbz) v = is_rem ? a : '1;
    else     v = is_rem ? '0 : a;
    return word ? f_sext32(v) : v;
  endfunction

  // Registers
  logic [1:0]      r_f3;
  logic            r_word;
  logic [XLEN-1:0] r_a, r_b;
  logic [XLEN-1:0] r_rem, r_quo, r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_negq, r_negr, r_dbz, r_ovf;
  logic [XLEN-1:0] r_result;

  // Accept-side decode
  logic            w_accept, w_in_word, w_in_sgn, w_in_dbz, w_in_ovf, w_fast;
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_quo_init;

  assign w_accept  = in_valid_i & in_ready_o;
  assign w_in_word = (XLEN == 64) && word_i;
  assign w_in_sgn  = ~funct3_i[0];

  always_comb begin
    w_a_ext = srcA_i;
    w_b_ext = srcB_i;
    if (w_in_word) begin
      w_a_ext = w_in_sgn ? f_sext32(srcA_i) : f_zext32(srcA_i);
      w_b_ext = w_in_sgn ? f_sext32(srcB_i) : f_zext32(srcB_i);
    end
    w_a_neg = w_in_sgn & w_a_ext[XLEN-1];
    w_b_neg = w_in_sgn & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? ('0 - w_a_ext) : w_a_ext;
    w_b_mag = w_b_neg ? ('0 - w_b_ext) : w_b_ext;
    // Word dividends are left-aligned so the same MSB-first loop serves both widths.
    w_quo_init = w_in_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
  end

  assign w_in_dbz = w_in_word ? (srcB_i[31:0] == 32'd0) : (srcB_i == '0);
  assign w_in_ovf = w_in_sgn & (w_in_word
                    ? ((srcA_i[31:0] == 32'h8000_0000) && (srcB_i[31:0] == 32'hFFFF_FFFF))
                    : ((srcA_i == {1'b1, {(XLEN-1){1'b0}}}) && (srcB_i == '1)));

`ifdef MULDIV_DIV_FASTPATH_EN
  assign w_fast = funct3_i[2] & (w_in_dbz | w_in_ovf);
`else
  assign w_fast = 1'b0;
`endif

  // Multiplier: operands widened to 2*XLEN with per-op signedness
  logic                   w_a_s, w_b_s;
  logic signed [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0]        w_mul_res;

  assign w_a_s = (r_f3 == 2'b01) | (r_f3 == 2'b10);
  assign w_b_s = (r_f3 == 2'b01);
  assign w_ma  = {{XLEN{w_a_s & r_a[XLEN-1]}}, r_a};
  assign w_mb  = {{XLEN{w_b_s & r_b[XLEN-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  always_comb begin
    if (r_word)              w_mul_res = f_sext32(w_prod[XLEN-1:0]);
    else if (r_f3 == 2'b00)  w_mul_res = w_prod[XLEN-1:0];
    else                     w_mul_res = w_prod[2*XLEN-1:XLEN];
  end

  // Restoring divide step
  logic [XLEN:0]   w_shift;
  logic            w_ge, w_last;
  logic [XLEN-1:0] w_diff, w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix, w_div_val, w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = w_shift >= {1'b0, r_div};
  assign w_diff    = w_shift[XLEN-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_last    = r_word ? (r_cnt == CW'(31)) : (r_cnt == CW'(XLEN - 1));

  always_comb begin
    w_q_fix   = r_negq ? ('0 - w_quo_nxt) : w_quo_nxt;
    w_r_fix   = r_negr ? ('0 - w_rem_nxt) : w_rem_nxt;
    w_div_val = r_f3[1] ? w_r_fix : w_q_fix;
    if (r_dbz | r_ovf) w_div_res = f_special(r_a, r_f3[1], r_dbz, r_word);
    else if (r_word)   w_div_res = f_sext32(w_div_val);
    else               w_div_res = w_div_val;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = funct3_i[2] ? (w_fast ? S_DONE : S_DIV) : S_MUL;
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  // Outputs
  always_comb begin
    in_ready_o  = (r_state == S_IDLE) & ~flush_i;
    busy_o      = (r_state != S_IDLE);
    out_valid_o = (r_state == S_DONE);
    result_o    = r_result;
  end

  // Datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_f3     <= '0;
      r_word   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3   <= funct3_i[1:0];
      r_word <= w_in_word;
      r_a    <= srcA_i;
      r_b    <= srcB_i;
      r_rem  <= '0;
      r_quo  <= w_quo_init;
      r_div  <= w_b_mag;
      r_cnt  <= '0;
      r_negq <= w_a_neg ^ w_b_neg;
      r_negr <= w_a_neg;
      r_dbz  <= w_in_dbz;
      r_ovf  <= w_in_ovf;
      if (w_fast) r_result <= f_special(srcA_i, funct3_i[1], w_in_dbz, w_in_word);
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_div_res;
    end else if (r_state == S_MUL) begin
      r_result <= w_mul_res;
    end
  end

endmodule
